cong_noi_tiep: RTL and testbench



---
 rtl/cong_noi_tiep.sv | 174 +++++++++++++++++
 tb/tb_cong_noi_tiep.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cong_noi_tiep.sv
// Digit-serial N-bit adder: streams one 2-bit digit per clock through cong_2bit, LSB first.
// Optional build macro CONG_OVF_EN adds a registered two's-complement overflow output (ovf).

module cong_2bit (
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic       Cin,
    output logic [1:0] S,
    output logic       C2
);
    assign {C2, S} = {1'b0, A} + {1'b0, B} + {2'b00, Cin};
endmodule

// Handshakes: a transfer happens on a rising clk edge where both valid and ready are high;
// start_ready is high only in IDLE, done_valid only in DONE, and sum_out/cout only change on RUN->DONE or reset.
module cong_noi_tiep #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic         cin,
    output logic [N-1:0] sum_out,
    output logic         cout,
    output logic         done_valid,
    input  logic         done_ready,
    output logic         busy
`ifdef CONG_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam int D  = N / 2;
    localparam int CW = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_sh_q, a_sh_d;
    logic [N-1:0]   b_sh_q, b_sh_d;
    logic [N-1:0]   sum_sh_q, sum_sh_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;

    logic [1:0]     slice_s;
    logic           slice_c2;
    logic [N-1:0]   sum_shift;

    cong_2bit u_slice (
        .A   (a_sh_q[1:0]),
        .B   (b_sh_q[1:0]),
        .Cin (carry_q),
        .S   (slice_s),
        .C2  (slice_c2)
    );

`ifdef CONG_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    // Partial sum fills from the top, so after D digits digit 0 lands at bits [1:0].
    always_comb begin
        sum_shift = sum_sh_q >> 2;
        sum_shift[N-1 -: 2] = slice_s;
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef CONG_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_sh_d   = a_in;
                    b_sh_d   = b_in;
                    sum_sh_d = '0;
                    carry_d  = cin;
                    cnt_d    = '0;
`ifdef CONG_OVF_EN
                    a_msb_d  = a_in[N-1];
                    b_msb_d  = b_in[N-1];
`endif
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 2;
                b_sh_d   = b_sh_q >> 2;
                sum_sh_d = sum_shift;
                carry_d  = slice_c2;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(D - 1)) begin
                    sum_d   = sum_shift;
                    cout_d  = slice_c2;
`ifdef CONG_OVF_EN
                    ovf_d   = (a_msb_q == b_msb_q) && (sum_shift[N-1] != a_msb_q);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
`ifdef CONG_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
`ifdef CONG_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign start_ready = (state_q == IDLE);
    assign done_valid  = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign sum_out     = sum_q;
    assign cout        = cout_q;
`ifdef CONG_OVF_EN
    assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_cong_noi_tiep.sv
// Bench for cong_noi_tiep (N=8): directed and random operations, backpressure and reset-abort cases.
module tb_cong_noi_tiep;
    localparam int N = 8;
    localparam int D = N / 2;
    localparam int W = N + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [N-1:0] a_in, b_in;
    logic         cin;
    logic [N-1:0] sum_out;
    logic         cout;
    logic         done_valid;
    logic         done_ready;
    logic         busy;
`ifdef CONG_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_res;

    always #5 clk = ~clk;

    cong_noi_tiep #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .cin         (cin),
        .sum_out     (sum_out),
        .cout        (cout),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .busy        (busy)
`ifdef CONG_OVF_EN
        ,
        .ovf         (ovf)
`endif
    );

    // Expected word is {ovf, cout, sum}; ovf is zero when the feature is absent.
    function automatic logic [W-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        logic [N:0] s;
        logic       v;
        s = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
        v = 1'b0;
`ifdef CONG_OVF_EN
        v = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
`endif
        return {v, s};
    endfunction

    function automatic logic [W-1:0] got_res();
        logic v;
        v = 1'b0;
`ifdef CONG_OVF_EN
        v = ovf;
`endif
        return {v, cout, sum_out};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c, input int hold);
        int n;
        logic [W-1:0] e;
        n = 0;
        while (!start_ready && n < 20) begin
            tick();
            n++;
        end
        chk("start_ready_idle", 32'(start_ready), 32'd1);
        a_in = a;
        b_in = b;
        cin = c;
        start_valid = 1'b1;
        exp_q.push_back(model(a, b, c));
        tick();
        start_valid = 1'b0;
        a_in = 8'($urandom);
        b_in = 8'($urandom);
        cin  = 1'($urandom);
        chk("busy_run", 32'({start_ready, busy}), 32'b01);
        n = 0;
        while (!done_valid && n < 20) begin
            chk("held_in_run", 32'(got_res()), 32'(last_res));
            start_valid = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        start_valid = 1'b0;
        chk("latency", 32'(n), 32'(D));
        e = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            chk("held_in_done", 32'(got_res()), 32'(e));
            chk("no_accept_done", 32'({start_ready, done_valid}), 32'b01);
            start_valid = 1'($urandom_range(0, 1));
            tick();
        end
        start_valid = 1'b0;
        chk("done_valid", 32'(done_valid), 32'd1);
        chk("result", 32'(got_res()), 32'(e));
        last_res = e;
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        chk("idle_after_done", 32'({start_ready, busy, done_valid}), 32'b100);
    endtask

    initial begin
        rst = 1'b1;
        start_valid = 1'b0;
        done_ready = 1'b0;
        a_in = '0;
        b_in = '0;
        cin = 1'b0;
        last_res = '0;
        tick();
        tick();
        chk("reset_result", 32'(got_res()), 32'd0);
        chk("reset_flags", 32'({start_ready, busy, done_valid}), 32'b100);
        rst = 1'b0;
        tick();

        run_op(8'h5A, 8'h3C, 1'b0, 0);
        chk("dir_5a_3c", 32'({cout, sum_out}), 32'h096);
        run_op(8'hFF, 8'h01, 1'b0, 1);
        chk("dir_ff_01", 32'({cout, sum_out}), 32'h100);
        run_op(8'hFF, 8'h00, 1'b1, 0);
        chk("dir_ff_00_c", 32'({cout, sum_out}), 32'h100);
        run_op(8'h12, 8'h34, 1'b1, 6);
        chk("dir_backpressure", 32'({cout, sum_out}), 32'h047);

        // Abort during the second digit: no result, outputs back to reset values.
        a_in = 8'hAA;
        b_in = 8'h55;
        cin = 1'b0;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_flags", 32'({start_ready, busy, done_valid}), 32'b100);
        chk("abort_result", 32'(got_res()), 32'd0);
        last_res = '0;
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_done", 32'(done_valid), 32'd0);
            tick();
        end
        run_op(8'h01, 8'h01, 1'b0, 0);
        chk("dir_01_01", 32'({cout, sum_out}), 32'h002);

        // Reset wins over a simultaneous start.
        rst = 1'b1;
        start_valid = 1'b1;
        a_in = 8'h33;
        b_in = 8'h44;
        tick();
        rst = 1'b0;
        start_valid = 1'b0;
        last_res = '0;
        for (int i = 0; i < 6; i++) begin
            chk("rst_beats_start", 32'({start_ready, busy, done_valid}), 32'b100);
            tick();
        end

`ifdef CONG_OVF_EN
        run_op(8'h7F, 8'h01, 1'b0, 0);
        chk("ovf_7f_01", 32'({ovf, cout, sum_out}), 32'h280);
        run_op(8'h80, 8'h80, 1'b0, 0);
        chk("ovf_80_80", 32'({ovf, cout, sum_out}), 32'h300);
        run_op(8'h10, 8'h20, 1'b0, 0);
        chk("ovf_10_20", 32'({ovf, cout, sum_out}), 32'h030);
`endif

        for (int k = 0; k < 24; k++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
